// File: rtl/signed_arith_seq.sv
// ----------------------------------------------------------------------------
// signed_arith_seq
//
// Sequential signed arithmetic core: add, subtract, multiply and
// multiply-accumulate on two's-complement operands. Add and subtract finish
// one cycle after the start edge. Multiply and multiply-accumulate use a
// sign-magnitude radix-2 shift-add multiplier, so they finish WIDTH cycles
// after the start edge. All internal arithmetic is exact. The exact value is
// then fitted into OUT_W bits. When it does not fit, ovf is raised and the
// value is either clamped (SATURATE=1) or wrapped (SATURATE=0).
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only while idle
//   op       00 add, 01 sub (a-b), 10 mul, 11 mac (acc + a*b)
//   a, b     signed WIDTH-bit operands, latched on the start edge
//   clr_acc  synchronous accumulator clear, honoured only while idle
//   busy     high while an operation is in progress
//   done     one-cycle pulse when result/ovf are updated
//   result   signed OUT_W-bit result, held until the next done
//   ovf      exact result was not representable in OUT_W bits
// ----------------------------------------------------------------------------
module signed_arith_seq #(
  parameter int WIDTH    = 6,
  parameter int OUT_W    = 10,
  parameter bit SATURATE = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    clr_acc,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] result,
  output logic                    ovf
);

  // Full product width and the exact working width. The working width is
  // large enough for acc + product without loss, and therefore also for
  // a +/- b and for the bare product.
  localparam int PROD_W = 2 * WIDTH;
  localparam int EXT_W  = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;
  localparam int CNT_W  = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  // Representable output limits, sign-extended to the working width.
  localparam logic [OUT_W-1:0] RES_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] RES_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W){1'b0}}, RES_MAX};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W){1'b1}}, RES_MIN};

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [1:0]              op_q;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic [PROD_W-1:0]       mcand_q;
  logic [WIDTH-1:0]        mplier_q;
  logic                    neg_q;
  logic [PROD_W-1:0]       prod_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [OUT_W-1:0] acc_q;

  logic                    last;
  logic [PROD_W-1:0]       prod_step;
  logic signed [EXT_W-1:0] a_ext;
  logic signed [EXT_W-1:0] b_ext;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] prod_ext;
  logic signed [EXT_W-1:0] exact_v;
  logic signed [OUT_W-1:0] fit_res;
  logic                    fit_ovf;

  // Magnitude of a WIDTH-bit signed value as a WIDTH-bit unsigned value.
  // The most negative operand maps to 2^(WIDTH-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] mag;
    mag = x;
    if (x[WIDTH-1]) begin
      mag = ~x + 1'b1;
    end
    return mag;
  endfunction

  // State register. An asynchronous reset drops any operation in flight
  // straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start is only considered while idle, so a start
  // during CALC is simply dropped rather than queued. busy mirrors the
  // CALC state, so it rises on the start edge and falls on the completion edge.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The counter holds the number of multiplier steps still to go after the
  // current one. Add/sub load it with zero, so their single CALC cycle is
  // also the last one.
  assign last = (cnt_q == '0);

  // One partial-product bit per cycle. On the final cycle the last bit is
  // folded in combinationally, so the registered product is never read
  // incomplete.
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  assign a_ext   = {{(EXT_W-WIDTH){a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{(EXT_W-WIDTH){b_q[WIDTH-1]}}, b_q};
  assign acc_ext = {{(EXT_W-OUT_W){acc_q[OUT_W-1]}}, acc_q};

  // Exact value of the latched operation in the working width. The unsigned
  // magnitude product is negated here when the operand signs differed.
  always_comb begin
    prod_ext = {{(EXT_W-PROD_W){1'b0}}, prod_step};
    if (neg_q) begin
      prod_ext = -prod_ext;
    end
    case (op_q)
      OP_ADD:  exact_v = a_ext + b_ext;
      OP_SUB:  exact_v = a_ext - b_ext;
      OP_MUL:  exact_v = prod_ext;
      OP_MAC:  exact_v = acc_ext + prod_ext;
      default: exact_v = '0;
    endcase
  end

  // Fit the exact value into OUT_W bits. The low bits are the wrapped value.
  // That value is also the result when the exact value fits, so saturation
  // only needs to override it on overflow.
  always_comb begin
    fit_ovf = 1'b0;
    fit_res = exact_v[OUT_W-1:0];
    if (exact_v > MAX_V) begin
      fit_ovf = 1'b1;
      if (SATURATE) begin
        fit_res = RES_MAX;
      end
    end else if (exact_v < MIN_V) begin
      fit_ovf = 1'b1;
      if (SATURATE) begin
        fit_res = RES_MIN;
      end
    end
  end

  // Datapath. While idle, operands are captured on a start, and the
  // accumulator may be cleared. The clear takes effect on the same edge as
  // a start, and the accumulator is only read at completion, so a
  // simultaneous clear + mac sees acc = 0. While calculating, the multiplier
  // steps until the last cycle, and then the fitted result is published
  // with a one-cycle done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result   <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (clr_acc) begin
          acc_q <= '0;
        end
        if (start) begin
          op_q     <= op;
          a_q      <= a;
          b_q      <= b;
          mcand_q  <= {{WIDTH{1'b0}}, magnitude(a)};
          mplier_q <= magnitude(b);
          neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
          prod_q   <= '0;
          cnt_q    <= op[1] ? CNT_W'(WIDTH - 1) : '0;
        end
      end else begin
        if (!last) begin
          prod_q   <= prod_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
        end else begin
          result <= fit_res;
          ovf    <= fit_ovf;
          done   <= 1'b1;
          if (op_q == OP_MAC) begin
            acc_q <= fit_res;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_arith_seq.sv
// ----------------------------------------------------------------------------
// tb_signed_arith_seq
//
// Directed bench for signed_arith_seq. A saturating instance and a wrapping
// instance share the same stimulus. A behavioural model computes the exact
// integer result and fits it for each overflow policy. The expected values
// are queued when an operation is started, and popped when done appears.
// ----------------------------------------------------------------------------
module tb_signed_arith_seq;

  localparam int WIDTH = 6;
  localparam int OUT_W = 10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic             clr_acc = 1'b0;
  logic [1:0]       op      = 2'b00;
  logic [WIDTH-1:0] a       = '0;
  logic [WIDTH-1:0] b       = '0;

  logic             busy_s, done_s, ovf_s;
  logic [OUT_W-1:0] result_s;
  logic             busy_w, done_w, ovf_w;
  logic [OUT_W-1:0] result_w;

  int n_checks       = 0;
  int n_fail         = 0;
  int cyc            = 0;
  int done_count     = 0;
  int expected_dones = 0;

  longint acc_sat  = 0;
  longint acc_wrap = 0;

  typedef struct {
    string            tag;
    logic [OUT_W-1:0] rs;
    logic             os;
    logic [OUT_W-1:0] rw;
    logic             ow;
    int               lat;
    int               start_cyc;
  } exp_t;

  exp_t sb[$];

  signed_arith_seq #(.WIDTH(WIDTH), .OUT_W(OUT_W), .SATURATE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .clr_acc(clr_acc), .busy(busy_s), .done(done_s), .result(result_s), .ovf(ovf_s)
  );

  signed_arith_seq #(.WIDTH(WIDTH), .OUT_W(OUT_W), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .clr_acc(clr_acc), .busy(busy_w), .done(done_w), .result(result_w), .ovf(ovf_w)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure latency from the start edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Count every done pulse, so that stray or missing pulses can be detected.
  always @(negedge clk) begin
    if (done_s === 1'b1) done_count = done_count + 1;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Fit an exact integer into OUT_W bits, clamping or wrapping.
  function automatic void fitModel(input longint v, input bit sat,
                                   output logic [OUT_W-1:0] r, output logic o);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    o  = (v > hi) || (v < lo);
    if (o && sat) r = (v > hi) ? OUT_W'(hi) : OUT_W'(lo);
    else          r = OUT_W'(v);
  endfunction

  // Drive one start (optionally with clr_acc) and queue the model's expectation.
  task automatic applyStimulus(input logic [1:0] o, input int av, input int bv,
                               input bit clr, input string tag);
    exp_t             e;
    longint           va, vb, vs, vw;
    logic [OUT_W-1:0] r_s, r_w;
    logic             o_s, o_w;
    @(negedge clk);
    op      = o;
    a       = av[WIDTH-1:0];
    b       = bv[WIDTH-1:0];
    clr_acc = clr;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    clr_acc = 1'b0;
    if (clr) begin
      acc_sat  = 0;
      acc_wrap = 0;
    end
    va = av;
    vb = bv;
    case (o)
      OP_ADD:  begin vs = va + vb; vw = vs; end
      OP_SUB:  begin vs = va - vb; vw = vs; end
      OP_MUL:  begin vs = va * vb; vw = vs; end
      default: begin vs = acc_sat + va * vb; vw = acc_wrap + va * vb; end
    endcase
    fitModel(vs, 1'b1, r_s, o_s);
    fitModel(vw, 1'b0, r_w, o_w);
    if (o == OP_MAC) begin
      acc_sat  = longint'($signed(r_s));
      acc_wrap = longint'($signed(r_w));
    end
    e.tag       = tag;
    e.rs        = r_s;
    e.os        = o_s;
    e.rw        = r_w;
    e.ow        = o_w;
    e.lat       = o[1] ? WIDTH : 1;
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic clearAcc();
    @(negedge clk);
    clr_acc = 1'b1;
    @(posedge clk);
    #1;
    clr_acc  = 1'b0;
    acc_sat  = 0;
    acc_wrap = 0;
  endtask

  // Wait (bounded) for done, then pop the oldest expectation and compare.
  task automatic checkOutput();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_s === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkValue("done_seen", {31'd0, seen}, 32'd1);
    checkValue("sb_size", sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        expected_dones++;
        checkValue({e.tag, "_latency"}, cyc - e.start_cyc, e.lat);
        checkValue({e.tag, "_result"}, result_s, e.rs);
        checkValue({e.tag, "_ovf"}, ovf_s, e.os);
        checkValue({e.tag, "_result_wrap"}, result_w, e.rw);
        checkValue({e.tag, "_ovf_wrap"}, ovf_w, e.ow);
        checkValue({e.tag, "_done_wrap"}, done_w, 1'b1);
        checkValue({e.tag, "_busy_low"}, busy_s, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkValue("rst_result", result_s, '0);
    checkValue("rst_ovf", ovf_s, 1'b0);
    checkValue("rst_busy", busy_s, 1'b0);
    checkValue("rst_done", done_s, 1'b0);
    checkValue("rst_result_wrap", result_w, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add / sub, including the extreme sub operand pair
    applyStimulus(OP_ADD, 1, 2, 1'b0, "add_1_2");
    checkOutput();
    applyStimulus(OP_ADD, -3, 2, 1'b0, "add_m3_2");
    checkOutput();
    applyStimulus(OP_SUB, -32, 31, 1'b0, "sub_m32_31");
    checkOutput();

    // Multiply; operands change and a start pulse arrives while busy
    applyStimulus(OP_MUL, 11, -7, 1'b0, "mul_11_m7");
    a  = 6'd5;
    b  = 6'd5;
    op = OP_ADD;
    @(negedge clk);
    checkValue("mul_busy", busy_s, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput();
    repeat (4) @(negedge clk);
    #1;
    checkValue("no_extra_done", done_count, expected_dones);

    // Most negative squared: overflow, saturate vs wrap
    applyStimulus(OP_MUL, -32, -32, 1'b0, "mul_m32_m32");
    checkOutput();

    // Accumulator sequence
    clearAcc();
    applyStimulus(OP_MAC, 20, 20, 1'b0, "mac1");
    checkOutput();
    applyStimulus(OP_MAC, 20, 20, 1'b0, "mac2");
    checkOutput();
    applyStimulus(OP_MAC, -32, 1, 1'b0, "mac3");
    checkOutput();
    applyStimulus(OP_MAC, 3, 3, 1'b1, "mac_clr");
    checkOutput();

    // A few pseudo-random operations across all opcodes
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'(i % 4), int'($urandom_range(63)) - 32,
                    int'($urandom_range(63)) - 32, 1'b0, "rand");
      checkOutput();
    end

    // start held high: alternating busy/idle with one idle cycle in between
    @(negedge clk);
    op    = OP_ADD;
    a     = 6'd1;
    b     = 6'd1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkValue("held_busy", busy_s, 1'b1);
      checkValue("held_done_low", done_s, 1'b0);
      @(negedge clk);
      checkValue("held_idle", busy_s, 1'b0);
      checkValue("held_done", done_s, 1'b1);
      checkValue("held_result", result_s, 10'd2);
      expected_dones++;
    end
    start = 1'b0;

    // Reset in the middle of a multiply
    applyStimulus(OP_MUL, 11, -7, 1'b0, "mul_abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkValue("abort_busy", busy_s, 1'b0);
    checkValue("abort_done", done_s, 1'b0);
    checkValue("abort_result", result_s, '0);
    checkValue("abort_ovf", ovf_s, 1'b0);
    sb.delete();
    acc_sat  = 0;
    acc_wrap = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkValue("abort_no_done", done_count, expected_dones);
    applyStimulus(OP_MAC, 1, 1, 1'b0, "mac_after_reset");
    checkOutput();

    repeat (3) @(negedge clk);
    #1;
    checkValue("sb_empty", sb.size(), 32'd0);
    checkValue("done_total", done_count, expected_dones);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_arith_seq.md
Name: signed_arith_seq

Overview:
- Parametrised, sequential signed arithmetic unit: add, subtract, multiply and multiply-accumulate on two's-complement operands.
- Result width and the overflow policy (saturate or wrap) are parameters.
- Overflow is flagged explicitly, never silently truncated.
- Sits in the datapath lab blocks as the reusable arithmetic core. Start/busy/done handshake; multi-cycle shift-add multiplier.

Parameters:
- WIDTH, 6, operand width in bits (signed), >=2
- OUT_W, 10, result and accumulator width in bits (signed), >=WIDTH+1
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low OUT_W bits)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 add, 01 sub (a-b), 10 mul, 11 mac (acc + a*b)
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- clr_acc  in  1  synchronous accumulator clear; honoured only in IDLE
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; result/ovf valid
- result  out  OUT_W  signed result, held until next done
- ovf  out  1  exact result not representable in OUT_W; held with result

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; result=0, ovf=0, done=0, busy=0, accumulator=0.
  - Reset mid-operation aborts it: no done pulse, partial product discarded.
- States: IDLE, CALC.
  - IDLE -> CALC on a clock edge with start=1. On that edge: a, b and op are latched, iteration counter is loaded, busy=1.
  - Operand changes after the start edge have no effect.
- Latency L:
  - add/sub: L=1. mul/mac: L=WIDTH.
  - Start accepted at edge k -> result, ovf and done update at edge k+L; busy falls at edge k+L.
  - done is high for exactly the cycle following edge k+L.
- start while busy is ignored, not queued. start during the done cycle is accepted (state is IDLE).
- Multiplier: sign-magnitude, radix-2 shift-add.
  - Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| fits.
  - One partial-product bit per cycle. Product is negated at completion when the signs differ.
  - Full product is 2*WIDTH bits, exact.
- Internal precision is exact:
  - add/sub: WIDTH+1 bits.
  - mac: max(2*WIDTH, OUT_W)+1 bits, computing acc + product.
  - No intermediate truncation.
- Output fitting of the exact value v:
  - If -2^(OUT_W-1) <= v <= 2^(OUT_W-1)-1: result=v, ovf=0.
  - Else ovf=1. SATURATE=1: result clamps to the nearer limit. SATURATE=0: result = v mod 2^OUT_W, as two's complement.
- Accumulator:
  - mac writes the fitted result into the accumulator; add/sub/mul leave it unchanged.
  - clr_acc=1 in IDLE zeroes the accumulator at the clock edge.
  - clr_acc and start(op=mac) on the same edge: clear takes priority, so the mac uses acc=0.
  - clr_acc while busy is ignored.
- Inputs containing X/Z: outputs unspecified, but done and busy timing are unaffected.

Test Plan:
- WIDTH=6, OUT_W=10, SATURATE=1, add a=1,b=2 -> done 1 cycle after start edge, result=3, ovf=0. Then a=-3,b=2 -> result=10'b1111111111 (-1), ovf=0. Then sub a=-32,b=31 -> result=-63, ovf=0.
- mul a=11,b=-7 -> busy for 6 cycles, done at start+6, result=10'b1110110011 (-77), ovf=0. Changing a/b while busy leaves the result unchanged.
- mul a=-32,b=-32 -> v=1024 -> result=511, ovf=1. Repeat with SATURATE=0 -> result=0, ovf=1.
- clr_acc, then mac(20,20) -> 400, ovf=0. Then mac(20,20) -> v=800 -> 511, ovf=1. Then mac(-32,1) -> 479, ovf=0. clr_acc with start mac(3,3) on the same edge -> result=9.
- Handshake: start held high continuously -> back-to-back operations with exactly one IDLE cycle between busy periods. A start pulse during busy -> no extra done.
- rst_n pulled low mid-mul (cycle 3) -> busy=0, done never pulses, result=0, acc=0. A new start after release completes normally.
